// File: rtl/tau_chain_router.sv
// Result router: buffers upstream result beats in a small FIFO and steers
// them, two at a time, either to the next transform stage (chain) or to the
// external result stream (out).
module tau_chain_router #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned DEST_WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned CHAIN_DEST_OFFSET = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chain_disable,
  input  logic                  soft_reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] chain_data,
  output logic [DEST_WIDTH-1:0] chain_dest,
  output logic                  chain_valid,
  input  logic                  chain_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned ADDR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + DEST_WIDTH;

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  ready_en;
  logic [ENTRY_W-1:0]    head;

  logic [DATA_WIDTH-1:0] reg_data;
  logic [DEST_WIDTH-1:0] reg_dest;
  logic                  reg_route;
  logic                  reg_valid;
  logic                  pair_phase;
  logic                  route_sel;

  logic                  push;
  logic                  pop;
  logic                  out_fire;
  logic                  pop_route;

  // FIFO status and handshake decode
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    in_ready   = ready_en & ~fifo_full & ~soft_reset;
    push       = in_valid & in_ready;
    out_fire   = reg_valid & (reg_route ? out_ready : chain_ready);
    pop        = ~fifo_empty & (~reg_valid | out_fire) & ~soft_reset;
    // second beat of a pair follows the first, whatever chain_disable does now
    pop_route  = pair_phase ? route_sel : chain_disable;
    head       = mem[rd_ptr[ADDR_W-1:0]];
  end

  // FIFO storage, no reset needed since pointers qualify every read
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {in_data, in_dest};
    end
  end

  // FIFO pointers and post-reset ready enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (soft_reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      end
    end
  end

  // Output register with pair-locked routing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_data   <= '0;
      reg_dest   <= '0;
      reg_route  <= 1'b1;
      reg_valid  <= 1'b0;
      pair_phase <= 1'b0;
      route_sel  <= 1'b1;
    end else if (soft_reset) begin
      reg_valid  <= 1'b0;
      pair_phase <= 1'b0;
    end else if (pop) begin
      reg_data   <= head[ENTRY_W-1:DEST_WIDTH];
      reg_dest   <= head[DEST_WIDTH-1:0];
      reg_route  <= pop_route;
      reg_valid  <= 1'b1;
      pair_phase <= ~pair_phase;
      if (!pair_phase) route_sel <= chain_disable;
    end else if (out_fire) begin
      reg_valid  <= 1'b0;
    end
  end

  // Output steering; chained beats get their destination rebased
  always_comb begin
    out_valid   = reg_valid & reg_route;
    chain_valid = reg_valid & ~reg_route;
    out_data    = reg_data;
    out_dest    = reg_dest;
    chain_data  = reg_data;
    chain_dest  = reg_dest + DEST_WIDTH'(CHAIN_DEST_OFFSET);
    busy        = ~fifo_empty | reg_valid;
  end

endmodule

// File: tb/tb_tau_chain_router.sv
// Scoreboard bench for tau_chain_router: stimulus queues expected beats,
// a monitor pops and compares on every output handshake.
module tb_tau_chain_router;

  localparam int unsigned DW  = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned FD  = 4;
  localparam int unsigned OFF = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          chain_disable = 1'b1;
  logic          soft_reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [TW-1:0] in_dest = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] chain_data;
  logic [TW-1:0] chain_dest;
  logic          chain_valid;
  logic          chain_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_dest;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  bit rand_rdy = 1'b0;
  bit dir_or   = 1'b0;
  bit dir_cr   = 1'b0;
  bit skip_mon = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          route;
    logic [DW-1:0] data;
    logic [TW-1:0] dest;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  tau_chain_router #(
    .DATA_WIDTH(DW), .DEST_WIDTH(TW), .FIFO_DEPTH(FD), .CHAIN_DEST_OFFSET(OFF)
  ) dut (
    .clock(clock), .reset(reset), .chain_disable(chain_disable), .soft_reset(soft_reset),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .chain_data(chain_data), .chain_dest(chain_dest), .chain_valid(chain_valid),
    .chain_ready(chain_ready),
    .out_data(out_data), .out_dest(out_dest), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  // Reference: out keeps the tag, chain adds the offset modulo 2^TW
  function automatic exp_t mk(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic r);
    exp_t e;
    e.route = r;
    e.data  = d;
    e.dest  = r ? t : TW'((int'(t) + int'(OFF)) % (1 << TW));
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Offer one beat; returns one step after the accepting edge
  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic r);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_data  = d;
    in_dest  = t;
    in_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc) sb.push_back(mk(d, t, r));
    else begin
      errors++;
      $display("FAIL accept_timeout actual=%0d cycles required=accept", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  task automatic mon_beat(input logic r, input logic [DW-1:0] d, input logic [TW-1:0] t);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat actual=route%0d data=%0h dest=%0h required=none", r, d, t);
    end else begin
      e = sb.pop_front();
      chk("beat", 64'({r, d, t}), 64'(e));
    end
  endtask

  // Output monitor: exclusivity, stall stability, scoreboard compare
  task automatic monitor();
    bit o_hold, c_hold;
    logic [DW-1:0] o_d, c_d;
    logic [TW-1:0] o_t, c_t;
    o_hold = 1'b0;
    c_hold = 1'b0;
    o_d = '0; c_d = '0; o_t = '0; c_t = '0;
    forever begin
      @(negedge clock);
      if (reset || skip_mon) begin
        o_hold = 1'b0;
        c_hold = 1'b0;
      end else begin
        if (out_valid || chain_valid) chk("valid_exclusive", 64'(out_valid & chain_valid), 64'd0);
        if (o_hold) chk("out_stable", 64'({out_valid, out_data, out_dest}), 64'({1'b1, o_d, o_t}));
        if (c_hold) chk("chain_stable", 64'({chain_valid, chain_data, chain_dest}), 64'({1'b1, c_d, c_t}));
        if (out_valid && out_ready) mon_beat(1'b1, out_data, out_dest);
        if (chain_valid && chain_ready) mon_beat(1'b0, chain_data, chain_dest);
        o_hold = out_valid && !out_ready;
        c_hold = chain_valid && !chain_ready;
        o_d = out_data;   o_t = out_dest;
        c_d = chain_data; c_t = chain_dest;
      end
    end
  endtask

  // Ready driver: directed levels or random backpressure
  task automatic ready_drv();
    forever begin
      @(posedge clock);
      #2;
      if (rand_rdy) begin
        out_ready   = ($urandom % 4) != 0;
        chain_ready = ($urandom % 4) != 0;
      end else begin
        out_ready   = dir_or;
        chain_ready = dir_cr;
      end
    end
  endtask

  initial begin
    fork
      monitor();
      ready_drv();
    join_none

    // reset state, then in_ready on first edge after release
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_chain_valid", 64'(chain_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    step(1);
    chk("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    // to out, 2-cycle latency
    chain_disable = 1'b1;
    dir_or = 1'b1;
    dir_cr = 1'b1;
    step(1);
    send(32'h11, 8'd2, 1'b1);
    chk("latency_edge_k", 64'(out_valid), 64'd0);
    step(1);
    chk("latency_edge_k1", 64'({out_valid, chain_valid, out_data}), 64'({1'b1, 1'b0, 32'h11}));
    send(32'h22, 8'd3, 1'b1);
    drain();

    // to chain with dest offset
    chain_disable = 1'b0;
    send(32'h33, 8'd2, 1'b0);
    send(32'h44, 8'd3, 1'b0);
    drain();

    // chain_disable flips mid-pair
    send(32'hA0, 8'd10, 1'b0);
    step(2);
    chain_disable = 1'b1;
    send(32'hA1, 8'd11, 1'b0);
    send(32'hA2, 8'd12, 1'b1);
    send(32'hA3, 8'd13, 1'b1);
    drain();

    // full FIFO under stall
    dir_or = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) send(32'hB0 + 32'(i), TW'(20 + i), 1'b1);
    in_data  = 32'hB5;
    in_dest  = 8'd25;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("full_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("full_busy", 64'(busy), 64'd1);
    dir_or = 1'b1;
    drain();
    send(32'hC0, 8'd30, 1'b1);
    drain();

    // soft reset with three beats held, pair_phase left at 1
    dir_or = 1'b0;
    dir_cr = 1'b0;
    step(1);
    send(32'hD0, 8'd40, 1'b1);
    send(32'hD1, 8'd41, 1'b1);
    send(32'hD2, 8'd42, 1'b1);
    step(1);
    skip_mon   = 1'b1;
    soft_reset = 1'b1;
    @(negedge clock);
    chk("sr_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    chk("sr_flush", 64'({busy, out_valid, chain_valid}), 64'd0);
    sb.delete();
    skip_mon = 1'b0;
    chain_disable = 1'b0;
    dir_or = 1'b1;
    dir_cr = 1'b1;
    send(32'hE0, 8'd50, 1'b0);
    send(32'hE1, 8'd51, 1'b0);
    drain();

    // async reset mid-transfer
    dir_or = 1'b0;
    dir_cr = 1'b0;
    chain_disable = 1'b1;
    step(1);
    send(32'hF0, 8'd60, 1'b1);
    send(32'hF1, 8'd61, 1'b1);
    send(32'hF2, 8'd62, 1'b1);
    step(1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", 64'({in_ready, out_valid, chain_valid, busy}), 64'd0);
    sb.delete();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rel_before_edge", 64'(in_ready), 64'd0);
    step(1);
    chk("async_rel_after_edge", 64'(in_ready), 64'd1);

    // randomized pairs with random backpressure
    rand_rdy = 1'b1;
    for (int b = 0; b < 25; b++) begin
      int np;
      drain();
      chain_disable = 1'($urandom % 2);
      np = 1 + int'($urandom % 4);
      for (int k = 0; k < 2 * np; k++) begin
        send($urandom, TW'($urandom), chain_disable);
        if (($urandom % 3) == 0) step(1 + int'($urandom % 2));
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
